// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard for the pipelined RV32I core.
// Optional write-first read forwarding is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  output logic                iss_ok_o,
  input  logic                flush_i,
  output logic [AW:0]         pend_cnt_o,
  output logic                err_o
);

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [AW:0]      pend_cnt_r;
  logic [AW:0]      pend_nxt_s;
  logic             err_r;
  logic             err_nxt_s;
  logic             wr_live_s;
  logic             iss_ok_s;

  assign wr_live_s = wr_en_i & (wr_addr_i != {AW{1'b0}});

  // Issue acceptance: a same-cycle writeback to the destination frees it for reissue.
  always_comb begin
    iss_ok_s = 1'b0;
    if (iss_en_i && !flush_i) begin
      if ((iss_addr_i == {AW{1'b0}}) || !busy_r[iss_addr_i] ||
          (wr_en_i && (wr_addr_i == iss_addr_i))) begin
        iss_ok_s = 1'b1;
      end else begin
        iss_ok_s = 1'b0;
      end
    end else begin
      iss_ok_s = 1'b0;
    end
  end

  assign iss_ok_o = iss_ok_s;

  // Next scoreboard state: writeback clears, accepted issue sets (issue wins), flush clears all.
  always_comb begin
    busy_nxt_s = busy_r;
    err_nxt_s  = err_r;
    pend_nxt_s = {(AW+1){1'b0}};
    if (flush_i) begin
      busy_nxt_s = {NREGS{1'b0}};
    end else begin
      if (wr_live_s) begin
        busy_nxt_s[wr_addr_i] = 1'b0;
        if (!busy_r[wr_addr_i]) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
      end else begin
        busy_nxt_s = busy_r;
      end
      if (iss_ok_s && (iss_addr_i != {AW{1'b0}})) begin
        busy_nxt_s[iss_addr_i] = 1'b1;
      end else begin
        busy_nxt_s[0] = 1'b0;
      end
    end
    busy_nxt_s[0] = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      pend_nxt_s = pend_nxt_s + {{AW{1'b0}}, busy_nxt_s[i]};
    end
  end

  // Scoreboard, pending count and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= {NREGS{1'b0}};
      pend_cnt_r <= {(AW+1){1'b0}};
      err_r      <= 1'b0;
    end else begin
      busy_r     <= busy_nxt_s;
      pend_cnt_r <= pend_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  // Register storage; r0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_live_s) begin
      regs_r[wr_addr_i] <= wr_data_i;
    end
  end

  assign pend_cnt_o = pend_cnt_r;
  assign err_o      = err_r;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr_s;
    logic [XLEN-1:0] data_s;
    logic            busy_s;

    assign addr_s = rd_addr_i[k*AW +: AW];

    // Combinational read port with r0 forced to zero.
    always_comb begin
      data_s = {XLEN{1'b0}};
      busy_s = 1'b0;
      if (addr_s == {AW{1'b0}}) begin
        data_s = {XLEN{1'b0}};
        busy_s = 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
      end else if (wr_live_s && (wr_addr_i == addr_s)) begin
        data_s = wr_data_i;
        busy_s = 1'b0;
`endif
      end else begin
        data_s = regs_r[addr_s];
        busy_s = busy_r[addr_s];
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = data_s;
    assign rd_busy_o[k]              = busy_s;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                iss_ok;
  logic                flush;
  logic [AW:0]         pend_cnt;
  logic                err;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .iss_ok_o(iss_ok),
    .flush_i(flush), .pend_cnt_o(pend_cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [XLEN-1:0] m_reg [NREGS];
  bit              m_busy [NREGS];
  bit              m_err;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  function automatic bit model_ok();
    if (!iss_en || flush) return 1'b0;
    return (iss_addr == 0) || !m_busy[iss_addr] || (wr_en && wr_addr == iss_addr);
  endfunction

  function automatic int model_pend();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Apply inputs, then check the combinational outputs against the model.
  task automatic set(input bit we, input int wa, input logic [XLEN-1:0] wd,
                     input bit ie, input int ia, input bit fl, input int r0, input int r1);
    logic [XLEN-1:0] ed;
    bit              eb;
    int              a;
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    iss_en = ie; iss_addr = AW'(ia); flush = fl;
    rd_addr = {AW'(r1), AW'(r0)};
    #1;
    chk("iss_ok", {63'd0, iss_ok}, {63'd0, model_ok()});
    for (int k = 0; k < NRD; k++) begin
      a = (k == 0) ? r0 : r1;
      if (a == 0) begin
        ed = '0; eb = 1'b0;
      end else if (m_bypass() && we && wa == a) begin
        ed = wd; eb = 1'b0;
      end else begin
        ed = m_reg[a]; eb = m_busy[a];
      end
      chk("rd_data", {32'd0, rd_data[k*XLEN +: XLEN]}, {32'd0, ed});
      chk("rd_busy", {63'd0, rd_busy[k]}, {63'd0, eb});
    end
  endtask

  function automatic bit m_bypass();
`ifdef REGFILE_SB_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Clock edge: advance the model by the architectural rules, then check registered outputs.
  task automatic tick();
    bit ok;
    ok = model_ok();
    @(posedge clk);
    if (wr_en && wr_addr != 0) begin
      if (!flush && !m_busy[wr_addr]) m_err = 1'b1;
      m_reg[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else if (ok && iss_addr != 0) begin
      m_busy[iss_addr] = 1'b1;
    end
    #1;
    chk("pend_cnt", {58'd0, pend_cnt}, 64'(model_pend()));
    chk("err", {63'd0, err}, {63'd0, m_err});
  endtask

  task automatic idle(input int r0, input int r1);
    set(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, r0, r1);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = '0;
    #12 rst_n = 1'b1;
    #1;
    chk("reset_pend", {58'd0, pend_cnt}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);
    idle(5, 31);
    chk("reset_rd", {32'd0, rd_data[XLEN +: XLEN]}, 64'd0);

    // Issue r3, then write it back
    set(1'b0, 0, 32'h0, 1'b1, 3, 1'b0, 3, 3);
    tick();
    idle(3, 3);
    chk("r3_busy", {63'd0, rd_busy[0]}, 64'd1);
    chk("r3_pend", {58'd0, pend_cnt}, 64'd1);
    set(1'b1, 3, 32'hDEADBEEF, 1'b0, 0, 1'b0, 3, 3);
    tick();
    idle(3, 3);
    chk("r3_data", {32'd0, rd_data[XLEN-1:0]}, 64'hDEADBEEF);
    chk("r3_free", {63'd0, rd_busy[0]}, 64'd0);
    chk("r3_pend0", {58'd0, pend_cnt}, 64'd0);

    // WAW: reissue of busy r4 stalls unless it is written back in the same cycle
    set(1'b0, 0, 32'h0, 1'b1, 4, 1'b0, 4, 4);
    tick();
    set(1'b0, 0, 32'h0, 1'b1, 4, 1'b0, 4, 4);
    chk("r4_stall", {63'd0, iss_ok}, 64'd0);
    tick();
    set(1'b1, 4, 32'h55, 1'b1, 4, 1'b0, 4, 4);
    chk("r4_waw_ok", {63'd0, iss_ok}, 64'd1);
    tick();
    idle(4, 4);
    chk("r4_data", {32'd0, rd_data[XLEN-1:0]}, 64'h55);
    chk("r4_busy", {63'd0, rd_busy[1]}, 64'd1);
    chk("r4_pend", {58'd0, pend_cnt}, 64'd1);

    // r0 is immutable and never busy
    set(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 1'b0, 0, 0);
    chk("r0_iss_ok", {63'd0, iss_ok}, 64'd1);
    tick();
    idle(0, 0);
    chk("r0_zero", {32'd0, rd_data[XLEN-1:0]}, 64'd0);
    chk("r0_err", {63'd0, err}, 64'd0);

    // Writeback to an idle register flags a sticky error
    set(1'b1, 9, 32'hCAFE0009, 1'b0, 0, 1'b0, 9, 9);
    tick();
    chk("r9_err", {63'd0, err}, 64'd1);
    idle(9, 9);
    chk("r9_data", {32'd0, rd_data[XLEN-1:0]}, 64'hCAFE0009);
    tick();
    chk("r9_err_sticky", {63'd0, err}, 64'd1);

    // Flush clears every pending mark and rejects a concurrent issue
    set(1'b0, 0, 32'h0, 1'b1, 1, 1'b0, 1, 2); tick();
    set(1'b0, 0, 32'h0, 1'b1, 2, 1'b0, 1, 2); tick();
    set(1'b0, 0, 32'h0, 1'b1, 6, 1'b0, 1, 2); tick();
    chk("pre_flush_pend", {58'd0, pend_cnt}, 64'd4);
    set(1'b0, 0, 32'h0, 1'b1, 8, 1'b1, 1, 2);
    chk("flush_iss_rej", {63'd0, iss_ok}, 64'd0);
    tick();
    idle(6, 8);
    chk("flush_pend", {58'd0, pend_cnt}, 64'd0);
    chk("flush_busy", {62'd0, rd_busy}, 64'd0);
    idle(3, 4);
    chk("flush_data", {rd_data[XLEN +: XLEN], rd_data[XLEN-1:0]}, {32'h55, 32'hDEADBEEF});

    // Same-cycle writeback and read of busy r10 on every port
    set(1'b0, 0, 32'h0, 1'b1, 10, 1'b0, 10, 10); tick();
    set(1'b1, 10, 32'h11111111, 1'b0, 0, 1'b0, 10, 10); tick();
    set(1'b0, 0, 32'h0, 1'b1, 10, 1'b0, 10, 10); tick();
    set(1'b1, 10, 32'hA5A5A5A5, 1'b0, 0, 1'b0, 10, 10);
`ifdef REGFILE_SB_BYPASS_EN
    chk("byp_data", {rd_data[XLEN +: XLEN], rd_data[XLEN-1:0]}, {32'hA5A5A5A5, 32'hA5A5A5A5});
    chk("byp_busy", {62'd0, rd_busy}, 64'd0);
`else
    chk("nobyp_data", {rd_data[XLEN +: XLEN], rd_data[XLEN-1:0]}, {32'h11111111, 32'h11111111});
    chk("nobyp_busy", {62'd0, rd_busy}, 64'd3);
`endif
    tick();
    idle(10, 10);
    chk("r10_next", {rd_data[XLEN +: XLEN], rd_data[XLEN-1:0]}, {32'hA5A5A5A5, 32'hA5A5A5A5});

    // Asynchronous reset mid-run
    set(1'b1, 5, 32'h1234, 1'b0, 0, 1'b0, 5, 7); tick();
    set(1'b0, 0, 32'h0, 1'b1, 7, 1'b0, 5, 7); tick();
    idle(5, 7);
    chk("pre_rst_r5", {32'd0, rd_data[XLEN-1:0]}, 64'h1234);
    chk("pre_rst_r7", {63'd0, rd_busy[1]}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_rd", {rd_data[XLEN +: XLEN], rd_data[XLEN-1:0]}, 64'd0);
    chk("rst_busy", {62'd0, rd_busy}, 64'd0);
    chk("rst_pend", {58'd0, pend_cnt}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    model_reset();
    #3 rst_n = 1'b1;

    // Writeback concurrent with flush: data written, no error
    set(1'b1, 11, 32'h77, 1'b0, 0, 1'b1, 11, 11);
    tick();
    chk("flush_wr_err", {63'd0, err}, 64'd0);
    idle(11, 11);
    chk("flush_wr_data", {32'd0, rd_data[XLEN-1:0]}, 64'h77);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      set(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom(),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
